// File: rtl/msi001_cfg_seq_if.sv
// Host-side bundle for the MSI001 config sequencer: table write port,
// sequence control and the word stream toward the SPI serializer.
interface msi001_cfg_seq_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 24
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   word_cnt;
  logic [7:0]        gap_cycles;
  logic              start;
  logic [DATA_W-1:0] spi_word;
  logic              spi_valid;
  logic              spi_ready;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, word_cnt, gap_cycles, start, spi_ready,
    input  spi_word, spi_valid, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, word_cnt, gap_cycles, start, spi_ready,
    output spi_word, spi_valid, busy, done
  );
endinterface

// File: rtl/msi001_cfg_seq.sv
// MSI001 register-table sequencer: holds up to 2**ADDR_W words and streams the
// first word_cnt of them to the SPI serializer with a programmable idle gap.
module msi001_cfg_seq #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 24
) (
  input logic              clk,
  input logic              reset_n,
  msi001_cfg_seq_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, FIN} state_t;

  state_t            state;
  logic [DATA_W-1:0] table_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   cnt_q;
  logic [7:0]        gap_q;
  logic [7:0]        gap_cnt;
  logic              start_q;
  logic [DATA_W-1:0] spi_word_q;
  logic              spi_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W:0]   cnt_clip;
  logic              last;

  assign cnt_clip = (bus.word_cnt > DEPTH_C) ? DEPTH_C : bus.word_cnt;
  assign last     = ({1'b0, idx} == (cnt_q - (ADDR_W+1)'(1)));

  assign bus.spi_word  = spi_word_q;
  assign bus.spi_valid = spi_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (bus.wr_en && !busy_q) begin
      table_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // A start is captured into start_q together with count/gap; the following
  // edge launches the sequence, so the first word is valid two edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      start_q     <= 1'b0;
      spi_word_q  <= '0;
      spi_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_q) begin
            start_q <= 1'b0;
            idx     <= '0;
            busy_q  <= 1'b1;
            if (cnt_q == '0) begin
              state  <= FIN;
              done_q <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end else if (bus.start) begin
            cnt_q   <= cnt_clip;
            gap_q   <= bus.gap_cycles;
            start_q <= 1'b1;
          end
        end
        LOAD: begin
          spi_word_q  <= table_q[idx];
          spi_valid_q <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (bus.spi_ready) begin
            spi_valid_q <= 1'b0;
            if (last) begin
              state  <= FIN;
              done_q <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              if (gap_q != 8'd0) begin
                state   <= GAP;
                gap_cnt <= gap_q;
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'd1) begin
            gap_cnt <= 8'd0;
            state   <= LOAD;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state       <= IDLE;
          spi_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end
endmodule
